clock_set_ctrl: RTL and testbench
=================================

# clock_set_ctrl

Time-setting controller for the digital clock. Sequences the hours/minutes/seconds counter chain from three push-buttons: it debounces the keys, runs an edit state machine (run → set hour → set minute → commit), and freezes the seconds tick while editing. On commit it issues a single load pulse carrying the edited values, and it drives blink-blanking flags for the HEX field being edited. It sits between the board keys and the counter60/counter24 chain in the clock top level, replacing the raw-key load path.

## Interface

Parameters:
- DEBOUNCE_CYCLES, default 1000000: number of stable CLOCK_50 cycles (20 ms) before a key level is accepted.
- BLINK_CYCLES, default 25000000: half-period of the edit-field blink (0.5 s).

Ports:
- CLOCK_50  in  1  sole clock, 50 MHz; all state on its rising edge.
- RESET_N  in  1  asynchronous, active-low reset.
- key_mode_n  in  1  raw mode button, active-low, asynchronous to CLOCK_50.
- key_up_n  in  1  raw increment button, active-low.
- key_down_n  in  1  raw decrement button, active-low.
- cur_hour  in  5  current hours count, 0..23.
- cur_min  in  6  current minutes count, 0..59.
- run_en  out  1  high in RUN; gates the 1 Hz enable into the seconds counter.
- load  out  1  one-cycle commit pulse to all counters (seconds load 0).
- load_hour  out  5  hours value to load; valid while load is high and held afterwards.
- load_min  out  6  minutes value to load; same validity.
- blank_hour  out  1  high when HEX5/HEX4 must be blanked (blink).
- blank_min  out  1  high when HEX3/HEX2 must be blanked.
- mode  out  2  current state encoding: RUN=0, SET_HOUR=1, SET_MIN=2, COMMIT=3.

## Operation

- Each key passes through a 2-flop synchronizer, then a debouncer. The debouncer accepts a new level only after it has been stable for DEBOUNCE_CYCLES consecutive cycles. A press event is a one-cycle pulse on an accepted released→pressed transition. Releases generate no event. Holding a key gives no auto-repeat.
- FSM transitions:
  - RUN: a mode event captures edit_hour←cur_hour and edit_min←cur_min, then goes to SET_HOUR. Up/down events are ignored.
  - SET_HOUR: up gives edit_hour = (edit_hour+1) mod 24; down gives (edit_hour+23) mod 24. A mode event goes to SET_MIN.
  - SET_MIN: up gives (edit_min+1) mod 60; down gives (edit_min+59) mod 60. A mode event goes to COMMIT.
  - COMMIT: lasts exactly one cycle with load=1, then returns to RUN unconditionally.
- load_hour and load_min are driven from edit_hour and edit_min at all times.
- Arithmetic: the modulo wrap is explicit compare-and-select, not a % operator. A captured cur_hour > 23 or cur_min > 59 is clamped to 0 at capture.
- Simultaneous events:
  - Up and down in the same cycle: both discarded.
  - Mode with up/down in the same cycle: the state advances and the value is unchanged.
- Blink: a counter runs only in SET_HOUR and SET_MIN and clears on entry to each of those states. The blink phase toggles every BLINK_CYCLES. blank_hour = SET_HOUR & phase; blank_min = SET_MIN & phase. Both are 0 in RUN and COMMIT.
- Any up or down event clears the blink counter and phase, so the field becomes visible immediately.

## Timing

- Reset values: state RUN, run_en=1, load=0, blank_hour=0, blank_min=0, mode=0, edit_hour=0, edit_min=0. All debouncers are in the released state with counters at 0.
- Key latency: the raw edge to the event pulse takes 2 synchronizer cycles + DEBOUNCE_CYCLES + 1.
- Event to state or edit-register update: 1 cycle.
- Outputs are Moore, decoded from registers; there is no combinational path from key inputs to outputs.
- run_en falls in the cycle after the mode event. It rises in the cycle after COMMIT, so the load pulse always precedes the resumption of counting.
- Reset asserted mid-edit: edits are abandoned immediately and asynchronously. No load is issued, and the state is RUN on release.
- A key held across reset release is treated as released until it is stably pressed for DEBOUNCE_CYCLES, and then it produces one event.

## Structure

- Package clock_ctrl_pkg holds:
  - the state enum (RUN, SET_HOUR, SET_MIN, COMMIT) and its 2-bit width;
  - constants HOURS_MOD=24 and MINS_MOD=60;
  - widths HOUR_W=5 and MIN_W=6.
- Sub-module key_debounce contains the synchronizer, debounce counter and press-event pulse, parameterized by DEBOUNCE_CYCLES. It is instantiated three times.
- The FSM, edit registers and blink counter live in clock_set_ctrl.

## Test plan

All scenarios run with DEBOUNCE_CYCLES=4 and BLINK_CYCLES=8.

- Reset: RESET_N low while in SET_MIN with edit_min=30 → next sample shows mode=0, run_en=1, load=0, blank_*=0, with no load pulse ever issued.
- Capture and hour wrap: cur_hour=13, cur_min=45, one mode press → mode=1, run_en=0, edit_hour=13. Then 11 up presses → load_hour=0 (passes 23→0).
- Minute wrap down: in SET_MIN with edit_min=0, one down press → load_min=59. One up press → 0.
- Bounce rejection: key_up_n low pulses of 3 cycles separated by 2 high cycles, 10 times → edit value unchanged. Then a stable low for 6 cycles → exactly one increment.
- Full commit: starting from 04:06, press mode, up, mode, up, mode → exactly one cycle with load=1, load_hour=5, load_min=7, then mode=0 and run_en=1 on the following cycle.
- Simultaneous events:
  - Up and down events in the same cycle in SET_HOUR → value unchanged.
  - Mode and up in the same cycle → mode=2, edit_hour unchanged.
  - blank_hour toggles every 8 cycles in SET_HOUR and resets to 0 on an up event.

Source files
------------

// File: rtl/clock_ctrl_pkg.sv
// Shared types, widths and wrap helpers for the clock time-setting controller.
package clock_ctrl_pkg;

   localparam int unsigned STATE_W   = 2;
   localparam int unsigned HOURS_MOD = 24;
   localparam int unsigned MINS_MOD  = 60;
   localparam int unsigned HOUR_W    = 5;
   localparam int unsigned MIN_W     = 6;

   typedef enum logic [STATE_W-1:0] {
      RUN      = 2'd0,
      SET_HOUR = 2'd1,
      SET_MIN  = 2'd2,
      COMMIT   = 2'd3
   } state_t;

   // Wrap by compare-and-select so no divider is ever built.
   function automatic logic [HOUR_W-1:0] hour_step(input logic [HOUR_W-1:0] h,
                                                   input logic             up);
      if (up) return (h >= HOUR_W'(HOURS_MOD - 1)) ? '0 : h + 1'b1;
      else    return (h == '0) ? HOUR_W'(HOURS_MOD - 1) : h - 1'b1;
   endfunction

   function automatic logic [MIN_W-1:0] min_step(input logic [MIN_W-1:0] m,
                                                 input logic            up);
      if (up) return (m >= MIN_W'(MINS_MOD - 1)) ? '0 : m + 1'b1;
      else    return (m == '0) ? MIN_W'(MINS_MOD - 1) : m - 1'b1;
   endfunction

endpackage

// File: rtl/key_debounce.sv
// Two-flop synchronizer, stability debouncer and one-cycle press-event pulse
// for one active-low push-button.
module key_debounce #(
   parameter int unsigned DEBOUNCE_CYCLES = 1000000
) (
   input  logic clk,
   input  logic rst_n,
   input  logic key_n,
   output logic press
);

   localparam int unsigned CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

   logic [1:0]       sync_q;
   logic             stable_q;
   logic [CNT_W-1:0] cnt_q;
   logic             press_q;

   // Everything resets to "released", so a key held through reset must
   // still prove itself stable before it produces an event.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync_q   <= 2'b11;
         stable_q <= 1'b1;
         cnt_q    <= '0;
         press_q  <= 1'b0;
      end else begin
         sync_q  <= {sync_q[0], key_n};
         press_q <= 1'b0;
         if (sync_q[1] != stable_q) begin
            if (cnt_q == CNT_LAST) begin
               stable_q <= sync_q[1];
               cnt_q    <= '0;
               press_q  <= ~sync_q[1];
            end else begin
               cnt_q <= cnt_q + 1'b1;
            end
         end else begin
            cnt_q <= '0;
         end
      end
   end

   assign press = press_q;

endmodule

// File: rtl/clock_set_ctrl.sv
// Edit state machine for setting the clock: debounced keys step the hour and
// minute fields, commit issues one load pulse, and the edited field blinks.
module clock_set_ctrl
   import clock_ctrl_pkg::*;
#(
   parameter int unsigned DEBOUNCE_CYCLES = 1000000,
   parameter int unsigned BLINK_CYCLES    = 25000000
) (
   input  logic              CLOCK_50,
   input  logic              RESET_N,
   input  logic              key_mode_n,
   input  logic              key_up_n,
   input  logic              key_down_n,
   input  logic [HOUR_W-1:0] cur_hour,
   input  logic [MIN_W-1:0]  cur_min,
   output logic              run_en,
   output logic              load,
   output logic [HOUR_W-1:0] load_hour,
   output logic [MIN_W-1:0]  load_min,
   output logic              blank_hour,
   output logic              blank_min,
   output logic [1:0]        mode
);

   localparam int unsigned BLK_W = (BLINK_CYCLES > 1) ? $clog2(BLINK_CYCLES) : 1;
   localparam logic [BLK_W-1:0] BLK_LAST = BLK_W'(BLINK_CYCLES - 1);

   logic ev_mode, ev_up, ev_down;
   logic step_up, step_dn;

   state_t            state_q, state_d;
   logic [HOUR_W-1:0] edit_hour_q;
   logic [MIN_W-1:0]  edit_min_q;
   logic [BLK_W-1:0]  blink_cnt_q;
   logic              phase_q;
   logic              editing;

   key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_key_mode (
      .clk(CLOCK_50), .rst_n(RESET_N), .key_n(key_mode_n), .press(ev_mode));
   key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_key_up (
      .clk(CLOCK_50), .rst_n(RESET_N), .key_n(key_up_n), .press(ev_up));
   key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_key_down (
      .clk(CLOCK_50), .rst_n(RESET_N), .key_n(key_down_n), .press(ev_down));

   // Opposing events in one cycle cancel; a mode event also suppresses steps.
   assign step_up = ev_up & ~ev_down & ~ev_mode;
   assign step_dn = ev_down & ~ev_up & ~ev_mode;
   assign editing = (state_q == SET_HOUR) || (state_q == SET_MIN);

   always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
      if (!RESET_N) state_q <= RUN;
      else          state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         RUN:      if (ev_mode) state_d = SET_HOUR;
         SET_HOUR: if (ev_mode) state_d = SET_MIN;
         SET_MIN:  if (ev_mode) state_d = COMMIT;
         COMMIT:   state_d = RUN;
         default:  state_d = RUN;
      endcase
   end

   always_comb begin
      run_en     = (state_q == RUN);
      load       = (state_q == COMMIT);
      blank_hour = (state_q == SET_HOUR) & phase_q;
      blank_min  = (state_q == SET_MIN) & phase_q;
      mode       = state_q;
      load_hour  = edit_hour_q;
      load_min   = edit_min_q;
   end

   always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
      if (!RESET_N) begin
         edit_hour_q <= '0;
         edit_min_q  <= '0;
      end else begin
         unique case (state_q)
            RUN: if (ev_mode) begin
               edit_hour_q <= (cur_hour > HOUR_W'(HOURS_MOD - 1)) ? '0 : cur_hour;
               edit_min_q  <= (cur_min > MIN_W'(MINS_MOD - 1)) ? '0 : cur_min;
            end
            SET_HOUR: begin
               if (step_up)      edit_hour_q <= hour_step(edit_hour_q, 1'b1);
               else if (step_dn) edit_hour_q <= hour_step(edit_hour_q, 1'b0);
            end
            SET_MIN: begin
               if (step_up)      edit_min_q <= min_step(edit_min_q, 1'b1);
               else if (step_dn) edit_min_q <= min_step(edit_min_q, 1'b0);
            end
            default: ;
         endcase
      end
   end

   // Restart the blink on any state change or key step so the field shows at once.
   always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
      if (!RESET_N) begin
         blink_cnt_q <= '0;
         phase_q     <= 1'b0;
      end else if ((state_d != state_q) || !editing || ev_up || ev_down) begin
         blink_cnt_q <= '0;
         phase_q     <= 1'b0;
      end else if (blink_cnt_q == BLK_LAST) begin
         blink_cnt_q <= '0;
         phase_q     <= ~phase_q;
      end else begin
         blink_cnt_q <= blink_cnt_q + 1'b1;
      end
   end

endmodule

// File: tb/tb_clock_set_ctrl.sv
// Directed scoreboard bench for clock_set_ctrl with short debounce/blink times.
module tb_clock_set_ctrl;

   logic       CLOCK_50   = 1'b0;
   logic       RESET_N    = 1'b0;
   logic       key_mode_n = 1'b1;
   logic       key_up_n   = 1'b1;
   logic       key_down_n = 1'b1;
   logic [4:0] cur_hour   = '0;
   logic [5:0] cur_min    = '0;
   logic       run_en, load, blank_hour, blank_min;
   logic [4:0] load_hour;
   logic [5:0] load_min;
   logic [1:0] mode;

   int n_checks = 0;
   int n_fails  = 0;
   int load_cycles = 0;
   logic [4:0] last_lh = '0;
   logic [5:0] last_lm = '0;

   logic [31:0] exp_q[$];
   string       tag_q[$];

   clock_set_ctrl #(.DEBOUNCE_CYCLES(4), .BLINK_CYCLES(8)) dut (
      .CLOCK_50(CLOCK_50), .RESET_N(RESET_N),
      .key_mode_n(key_mode_n), .key_up_n(key_up_n), .key_down_n(key_down_n),
      .cur_hour(cur_hour), .cur_min(cur_min),
      .run_en(run_en), .load(load), .load_hour(load_hour), .load_min(load_min),
      .blank_hour(blank_hour), .blank_min(blank_min), .mode(mode));

   always #5 CLOCK_50 = ~CLOCK_50;

   always @(posedge CLOCK_50) begin
      if (RESET_N && load) begin
         load_cycles <= load_cycles + 1;
         last_lh     <= load_hour;
         last_lm     <= load_min;
      end
   end

   task automatic expect_val(input string tag, input logic [31:0] v);
      exp_q.push_back(v);
      tag_q.push_back(tag);
   endtask

   task automatic check(input logic [31:0] obs);
      logic [31:0] e;
      string t;
      n_checks++;
      if (exp_q.size() == 0) begin
         n_fails++;
         $error("FAIL scoreboard_empty: observed %0d, nothing expected", obs);
         return;
      end
      e = exp_q.pop_front();
      t = tag_q.pop_front();
      assert (obs === e) else begin
         n_fails++;
         $error("FAIL %s: observed %0d expected %0d", t, obs, e);
      end
   endtask

   task automatic timeout_fail(input string tag);
      n_checks++;
      n_fails++;
      $error("FAIL %s: observed timeout expected event", tag);
   endtask

   task automatic cycles(input int n);
      repeat (n) @(posedge CLOCK_50);
      #1;
   endtask

   task automatic press(input logic m, input logic u, input logic d);
      key_mode_n = ~m;
      key_up_n   = ~u;
      key_down_n = ~d;
      cycles(10);
      key_mode_n = 1'b1;
      key_up_n   = 1'b1;
      key_down_n = 1'b1;
      cycles(10);
   endtask

   initial begin
      int n;
      // Reset state
      cycles(3);
      expect_val("rst_mode", 0);   check(mode);
      expect_val("rst_run_en", 1); check(run_en);
      expect_val("rst_load", 0);   check(load);
      expect_val("rst_blank_h", 0); check(blank_hour);
      expect_val("rst_blank_m", 0); check(blank_min);
      expect_val("rst_load_hour", 0); check(load_hour);
      expect_val("rst_load_min", 0);  check(load_min);
      RESET_N = 1'b1;
      cycles(3);

      // Capture 13:45 and wrap hours upward
      cur_hour = 5'd13; cur_min = 6'd45;
      expect_val("cap_mode", 1);    expect_val("cap_run_en", 0);
      expect_val("cap_hour", 13);   expect_val("cap_min", 45);
      press(1, 0, 0);
      check(mode); check(run_en); check(load_hour); check(load_min);
      expect_val("hour_23", 23);
      repeat (10) press(0, 1, 0);
      check(load_hour);
      expect_val("hour_wrap_0", 0);
      press(0, 1, 0);
      check(load_hour);

      // Minutes: walk 45 up to 0, then down-wrap and back
      expect_val("setmin_mode", 2); expect_val("setmin_min", 45);
      press(1, 0, 0);
      check(mode); check(load_min);
      expect_val("min_up_wrap", 0);
      repeat (15) press(0, 1, 0);
      check(load_min);
      expect_val("min_down_wrap", 59);
      press(0, 0, 1);
      check(load_min);
      expect_val("min_up_again", 0);
      press(0, 1, 0);
      check(load_min);

      // Bounce rejection followed by one genuine press
      expect_val("bounce_reject", 0);
      repeat (10) begin
         key_up_n = 1'b0; cycles(3);
         key_up_n = 1'b1; cycles(2);
      end
      cycles(10);
      check(load_min);
      expect_val("stable_press", 1);
      key_up_n = 1'b0; cycles(6);
      key_up_n = 1'b1; cycles(12);
      check(load_min);

      // Commit 00:01
      expect_val("commit1_mode", 0);  expect_val("commit1_run", 1);
      expect_val("commit1_loads", 1); expect_val("commit1_lh", 0);
      expect_val("commit1_lm", 1);
      press(1, 0, 0);
      check(mode); check(run_en); check(load_cycles); check(last_lh); check(last_lm);

      // Full commit from 04:06 to 05:07
      cur_hour = 5'd4; cur_min = 6'd6;
      press(1, 0, 0); press(0, 1, 0); press(1, 0, 0); press(0, 1, 0);
      key_mode_n = 1'b0;
      n = 0;
      while (load !== 1'b1 && n < 20) begin cycles(1); n++; end
      if (n >= 20) timeout_fail("load_wait");
      expect_val("commit2_lh", 5);   expect_val("commit2_lm", 7);
      expect_val("commit2_mode", 3); expect_val("commit2_run", 0);
      check(load_hour); check(load_min); check(mode); check(run_en);
      cycles(1);
      expect_val("post_load", 0); expect_val("post_mode", 0); expect_val("post_run", 1);
      check(load); check(mode); check(run_en);
      key_mode_n = 1'b1;
      cycles(10);
      expect_val("load_once", 2);
      check(load_cycles);

      // Simultaneous up+down in SET_HOUR
      cur_hour = 5'd10; cur_min = 6'd30;
      press(1, 0, 0);
      expect_val("updown_hour", 10); expect_val("updown_mode", 1);
      press(0, 1, 1);
      check(load_hour); check(mode);

      // Blink period and clear on up event
      n = 0;
      while (blank_hour !== 1'b0 && n < 40) begin cycles(1); n++; end
      if (n >= 40) timeout_fail("blink_low_wait");
      n = 0;
      while (blank_hour !== 1'b1 && n < 40) begin cycles(1); n++; end
      if (n >= 40) timeout_fail("blink_high_wait");
      n = 0;
      while (blank_hour === 1'b1 && n < 40) begin cycles(1); n++; end
      expect_val("blink_high_len", 8); check(n);
      n = 0;
      while (blank_hour === 1'b0 && n < 40) begin cycles(1); n++; end
      expect_val("blink_low_len", 8); check(n);
      key_up_n = 1'b0;
      n = 0;
      while (load_hour === 5'd10 && n < 20) begin cycles(1); n++; end
      if (n >= 20) timeout_fail("up_event_wait");
      expect_val("blink_cleared", 0); expect_val("blink_up_hour", 11);
      check(blank_hour); check(load_hour);
      key_up_n = 1'b1;
      cycles(12);

      // Mode with up together: advance, value unchanged
      expect_val("modeup_mode", 2); expect_val("modeup_hour", 11);
      expect_val("modeup_min", 30);
      press(1, 1, 0);
      check(mode); check(load_hour); check(load_min);

      // Asynchronous reset mid-edit
      #3 RESET_N = 1'b0;
      #1;
      expect_val("arst_mode", 0);    expect_val("arst_run", 1);
      expect_val("arst_load", 0);    expect_val("arst_blank_h", 0);
      expect_val("arst_blank_m", 0); expect_val("arst_min", 0);
      check(mode); check(run_en); check(load); check(blank_hour);
      check(blank_min); check(load_min);
      cycles(2);
      RESET_N = 1'b1;
      cycles(3);
      expect_val("arst_rel_mode", 0); expect_val("arst_no_load", 2);
      check(mode); check(load_cycles);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
      $finish;
   end

endmodule
